fadd_pipe: RTL
==============

Name: fadd_pipe

Overview:
- Parametrised, handshaked successor to the 2-stage float adder.
- Generic IEEE-style add/subtract for any EXP_W/MAN_W, with a fixed 3-stage pipeline: align, add/normalise, round/pack.
- Adds valid/ready backpressure, a tag sideband, a subtract mode, proper special-value handling and guard/round/sticky rounding.
- Sits between the FPU issue logic and the writeback arbiter; one result per cycle when not stalled.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa width, excluding the hidden bit (>=4)
TAG_W, 4, sideband tag width carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  block accepts the pair this cycle
op  in  1  0 = x1+x2, 1 = x1-x2 (x2 sign inverted at entry)
x1  in  1+EXP_W+MAN_W  operand 1 {sign, exp, man}
x2  in  1+EXP_W+MAN_W  operand 2
in_tag  in  TAG_W  sideband tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
y  out  1+EXP_W+MAN_W  result
ovf  out  1  finite inputs produced ±inf
out_tag  out  TAG_W  tag of the result
busy  out  1  any stage holds a valid entry

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - All stage valid bits clear.
  - y, ovf, out_tag, out_valid read 0; busy reads 0.
  - in_ready reads 1 once rst deasserts.
- A reset asserted mid-stream discards every in-flight entry with no partial output.
- Transfer: an input transfers when in_valid && in_ready; an output transfers when out_valid && out_ready.
- Pipeline: stages S0, S1, S2, each with its own valid bit v[k].
  - S2 drives the outputs directly from registers.
  - Stage k loads when !v[k] || (stage k+1 can load), and S2 "unloads" when out_ready.
  - Bubbles collapse under this rule.
  - in_ready = !v[0] || S1 can load. It is combinational through the chain.
- Latency: exactly 3 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 per cycle.
- While out_valid && !out_ready, y, ovf and out_tag hold stable.
- S0 (align):
  - Apply op to the sign of x2.
  - Swap so the larger magnitude is lx (compare {exp, man}; on equal magnitude x1 is lx).
  - Shift the smaller significand right by the exponent difference, keeping guard, round and sticky bits. Sticky is the OR of all bits shifted past round.
  - If the shift is >= MAN_W+3, the smaller operand becomes sticky only.
  - Exponent 0 inputs are flushed to ±0 (no subnormals).
- S1 (add/normalise):
  - Add significands on equal signs, subtract otherwise.
  - Normalise: a carry-out shifts right by 1, merging the dropped bit into sticky; otherwise a leading-zero-count left shift.
  - Adjust the exponent. Width is EXP_W+2 signed to detect under/overflow.
- S2 (round/pack):
  - Round the normalised significand; a rounding carry renormalises and increments the exponent.
  - Exponent >= 2^EXP_W-1 gives ±inf with ovf=1.
  - Exponent <= 0 gives ±0 carrying the sign of lx, with ovf=0.
  - Exact cancellation (zero sum) gives +0.
- Specials, decided in S0 and carried as a flag:
  - Any NaN input, or inf + (-inf) after op, gives the canonical qNaN {0, all-ones exp, 1, zeros}.
  - inf with a finite operand gives that inf.
  - ovf=0 for all special results.

Optional Feature:
FADD_RNE_EN
- Defined: round-to-nearest-even. Increment when G && (R || S || lsb).
- Undefined: legacy round-half-up. Increment when G, ignoring R and S. This matches the current adder's results bit-exactly for normal inputs.
- Latency, ports and handshake are identical in both builds.

Decomposition:
- Shared package fpu_pkg holds:
  - localparams EXP_W/MAN_W defaults and derived FW = 1+EXP_W+MAN_W;
  - function exp_max(EXP_W);
  - canonical qNaN constant builder;
  - the S0→S1 and S1→S2 struct typedefs (sign, exp, significand, grs, special flag, tag).
- One sub-module fadd_lzc: parametrised leading-zero counter (width in, clog2 count out, zero flag), used in S1.

Test Plan:
- 0x3F800000 + 0x3F800000, op=0, out_ready=1 → 0x40000000 exactly 3 cycles later, ovf=0, out_tag echoes in_tag.
- op=1, 0x3F800000 − 0x3F800000 → 0x00000000. Also x1=0x40400000, x2=0x3F800000, op=1 → 0x40000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1. 0x7F800000 + 0xFF800000 → 0x7FC00000, ovf=0. 0x7F800000 + 0x3F800000 → 0x7F800000, ovf=0.
- Tie case 0x3F800000 + 0x33800000 → 0x3F800000 with FADD_RNE_EN, 0x3F800001 without. Also 0x3F800001 + 0x33800000 → 0x3F800002 in both builds.
- Stream tags 1..6 back-to-back while holding out_ready=0 for cycles 2–6:
  - in_ready falls once all 3 stages are full;
  - results emerge in tag order with none lost or duplicated;
  - y stays stable during the stall.
- Assert rst while 3 entries are in flight → out_valid/busy fall to 0 asynchronously, no stale result after release, first new input returns after 3 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, exponent/qNaN helpers and
// default-width stage records for the pipelined float adder.
package fpu_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned FW_DEF    = 1 + EXP_W_DEF + MAN_W_DEF;

    function automatic int unsigned exp_max(input int unsigned ew);
        return (32'd1 << ew) - 32'd1;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 128 bits.
    function automatic logic [127:0] qnan(input int unsigned ew, input int unsigned mw);
        logic [127:0] r;
        r = ((128'd1 << ew) - 128'd1) << mw;
        r = r | (128'd1 << (mw - 1));
        return r;
    endfunction

    typedef struct packed {
        logic                   sign;
        logic                   sub;
        logic [EXP_W_DEF-1:0]   exp;
        logic [MAN_W_DEF:0]     lsig;
        logic [MAN_W_DEF+3:0]   ssig;
        logic                   spec;
        logic                   nan;
        logic [TAG_W_DEF-1:0]   tag;
    } fadd_s01_t;

    typedef struct packed {
        logic                   sign;
        logic signed [EXP_W_DEF+1:0] exp;
        logic [MAN_W_DEF:0]     sig;
        logic [2:0]             grs;
        logic                   zero;
        logic                   spec;
        logic                   nan;
        logic [TAG_W_DEF-1:0]   tag;
    } fadd_s12_t;

endpackage

// File: rtl/fadd_lzc.sv
// Parametrised leading-zero counter; zero flags an all-zero input.
module fadd_lzc #(
    parameter int unsigned W = 27
) (
    input  logic [W-1:0]         a,
    output logic [$clog2(W)-1:0] cnt,
    output logic                 zero
);

    always_comb begin
        cnt  = '0;
        zero = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (zero && a[W-1-i]) begin
                cnt  = ($clog2(W))'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fadd_pipe.sv
// 3-stage handshaked float add/subtract (align, add/normalise, round/pack).
// FADD_RNE_EN selects round-to-nearest-even; default is legacy round-half-up.
module fadd_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   ovf,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int unsigned FW  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW  = MAN_W + 4;
    localparam int unsigned EW2 = EXP_W + 2;
    localparam int unsigned CW  = $clog2(SW);
    localparam logic [EXP_W-1:0]      EMAX   = EXP_W'(exp_max(EXP_W));
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(exp_max(EXP_W));
    localparam logic [FW-1:0]         QNAN   = FW'(qnan(EXP_W, MAN_W));

    // Stage records at this instance's widths; same layout as the fpu_pkg types.
    typedef struct packed {
        logic               sign;
        logic               sub;
        logic [EXP_W-1:0]   exp;
        logic [MAN_W:0]     lsig;
        logic [SW-1:0]      ssig;
        logic               spec;
        logic               nan;
        logic [TAG_W-1:0]   tag;
    } s01_t;

    typedef struct packed {
        logic                  sign;
        logic signed [EW2-1:0] exp;
        logic [MAN_W:0]        sig;
        logic [2:0]            grs;
        logic                  zero;
        logic                  spec;
        logic                  nan;
        logic [TAG_W-1:0]      tag;
    } s12_t;

    logic v0, v1, v2, ld0, ld1, ld2;
    s01_t a01, r01;
    s12_t b12, r12;
    logic [FW-1:0] yn;
    logic          ovfn;

    assign ld2       = !v2 || out_ready;
    assign ld1       = !v1 || ld2;
    assign ld0       = !v0 || ld1;
    assign in_ready  = ld0;
    assign out_valid = v2;
    assign busy      = v0 || v1 || v2;

    // S0: align
    logic             s1x, s2x, inf1, inf2, nan1, nan2, swap, lsgn, ssgn;
    logic [EXP_W-1:0] e1, e2, lexp, sexp, d;
    logic [MAN_W-1:0] m1, m2, mf1, mf2, lman, sman;
    logic [SW-1:0]    sfull, shifted, lost;

    always_comb begin
        a01   = '0;
        s1x   = x1[FW-1];
        s2x   = x2[FW-1] ^ op;
        e1    = x1[FW-2:MAN_W];
        e2    = x2[FW-2:MAN_W];
        m1    = x1[MAN_W-1:0];
        m2    = x2[MAN_W-1:0];
        inf1  = (e1 == EMAX) && (m1 == '0);
        inf2  = (e2 == EMAX) && (m2 == '0);
        nan1  = (e1 == EMAX) && (m1 != '0);
        nan2  = (e2 == EMAX) && (m2 != '0);
        mf1   = (e1 == '0) ? '0 : m1;
        mf2   = (e2 == '0) ? '0 : m2;
        swap  = {e2, mf2} > {e1, mf1};
        if (swap) {lsgn, lexp, lman, ssgn, sexp, sman} = {s2x, e2, mf2, s1x, e1, mf1};
        else      {lsgn, lexp, lman, ssgn, sexp, sman} = {s1x, e1, mf1, s2x, e2, mf2};
        d       = lexp - sexp;
        sfull   = {sexp != '0, sman, 3'b000};
        shifted = sfull >> d;
        lost    = sfull & ~({SW{1'b1}} << d);
        if (32'(d) >= 32'(SW - 1)) a01.ssig = {{(SW-1){1'b0}}, |sfull};
        else                       a01.ssig = {shifted[SW-1:1], shifted[0] | (|lost)};
        a01.spec = nan1 || nan2 || inf1 || inf2;
        a01.nan  = nan1 || nan2 || (inf1 && inf2 && (s1x != s2x));
        a01.sign = a01.spec ? (inf1 ? s1x : s2x) : lsgn;
        a01.sub  = lsgn ^ ssgn;
        a01.exp  = lexp;
        a01.lsig = {lexp != '0, lman};
        a01.tag  = in_tag;
    end

    // S1: add / normalise
    logic [SW:0]           sum;
    logic [SW-1:0]         nsig;
    logic [CW-1:0]         lz;
    logic                  lz_zero;
    logic signed [EW2-1:0] ebase, nexp;

    always_comb begin
        if (r01.sub) sum = {1'b0, r01.lsig, 3'b000} - {1'b0, r01.ssig};
        else         sum = {1'b0, r01.lsig, 3'b000} + {1'b0, r01.ssig};
    end

    fadd_lzc #(.W(SW)) u_lzc (.a(sum[SW-1:0]), .cnt(lz), .zero(lz_zero));

    always_comb begin
        b12   = '0;
        ebase = {2'b00, r01.exp};
        if (sum[SW]) begin
            nsig = {sum[SW:2], sum[1] | sum[0]};
            nexp = ebase + EW2'(1);
        end else begin
            nsig = sum[SW-1:0] << lz;
            nexp = ebase - EW2'(lz);
        end
        b12.sign = r01.sign;
        b12.exp  = nexp;
        b12.sig  = nsig[SW-1:3];
        b12.grs  = nsig[2:0];
        b12.zero = lz_zero && !sum[SW];
        b12.spec = r01.spec;
        b12.nan  = r01.nan;
        b12.tag  = r01.tag;
    end

    // S2: round / pack
    logic                  inc;
    logic [MAN_W+1:0]      rnd;
    logic [MAN_W-1:0]      man;
    logic signed [EW2-1:0] ef;

`ifdef FADD_RNE_EN
    assign inc = r12.grs[2] && (r12.grs[1] || r12.grs[0] || r12.sig[0]);
`else
    logic rs_unused;
    assign rs_unused = r12.grs[1] | r12.grs[0];
    assign inc       = r12.grs[2];
`endif

    always_comb begin
        rnd  = {1'b0, r12.sig} + {{(MAN_W+1){1'b0}}, inc};
        ovfn = 1'b0;
        if (rnd[MAN_W+1]) begin
            man = rnd[MAN_W:1];
            ef  = r12.exp + EW2'(1);
        end else begin
            man = rnd[MAN_W-1:0];
            ef  = r12.exp;
        end
        if (r12.nan)                        yn = QNAN;
        else if (r12.spec)                  yn = {r12.sign, EMAX, {MAN_W{1'b0}}};
        else if (r12.zero)                  yn = '0;
        else if (ef >= EMAX_S) begin
            yn   = {r12.sign, EMAX, {MAN_W{1'b0}}};
            ovfn = 1'b1;
        end
        else if (ef[EW2-1] || ef == '0)     yn = {r12.sign, {(FW-1){1'b0}}};
        else                                yn = {r12.sign, ef[EXP_W-1:0], man};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            r01     <= '0;
            r12     <= '0;
            y       <= '0;
            ovf     <= 1'b0;
            out_tag <= '0;
        end else begin
            if (ld0) begin
                v0 <= in_valid;
                if (in_valid) r01 <= a01;
            end
            if (ld1) begin
                v1 <= v0;
                if (v0) r12 <= b12;
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    y       <= yn;
                    ovf     <= ovfn;
                    out_tag <= r12.tag;
                end
            end
        end
    end

endmodule
